// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encodings and
// the sizing rule for its single cycle timer.
`timescale 1ns/1ps
package pll_lock_supervisor_pkg;

   typedef enum logic [1:0] {
      RST_PLL   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } sup_state_t;

   // Timer must hold as many distinct values as the longest of the three intervals.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop bit synchronizer with a selectable reset value; used for
// any asynchronous status input entering the board-clock domain.
`timescale 1ns/1ps
module sync_2ff (
   input  logic clk,
   input  logic rstn,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta_p0 <= rst_val;
         sync_p1 <= rst_val;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Closes the loop around the PLL: pulses PLL RST, waits for a stable LOCK,
// releases the system reset, and re-sequences on any loss of lock.
`timescale 1ns/1ps
module pll_lock_supervisor
   import pll_lock_supervisor_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 25,
   parameter int LOCK_TIMEOUT_CYCLES = 250000,
   parameter int LOCK_STABLE_CYCLES  = 2500,
   parameter int CNT_W               = 8
) (
   input  logic             clk_25MHz,
   input  logic             rstn,
   input  logic             locked_async,
   input  logic             clear_stats,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             ready,
   output logic             timeout_err,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int TMR_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

   // The timer starts at 0 on every state entry and counts down; a state's
   // interval ends when the timer reaches the negated (cycles-1) value.
   // STABLE ends one step earlier because the WAIT_LOCK cycle that saw
   // lock already counts toward the consecutive-lock window.
   localparam int STABLE_STEPS = (LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0;
   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(0 - (PLL_RST_CYCLES - 1));
   localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(0 - (LOCK_TIMEOUT_CYCLES - 1));
   localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(0 - STABLE_STEPS);

   sup_state_t       state;
   logic [TMR_W-1:0] timer;
   logic             locked_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   sync_2ff u_lock_sync (
      .clk     (clk_25MHz),
      .rstn    (rstn),
      .rst_val (1'b0),
      .d       (locked_async),
      .q       (locked_s)
   );

   always_ff @(posedge clk_25MHz) begin
      if (!rstn) begin
         state         <= RST_PLL;
         timer         <= '0;
         pll_rst       <= 1'b1;
         sys_rst_n     <= 1'b0;
         ready         <= 1'b0;
         timeout_err   <= 1'b0;
         lock_loss_cnt <= '0;
         timeout_cnt   <= '0;
      end else begin
         timer <= timer - 1'b1;
         case (state)
            RST_PLL: begin
               if (timer == RST_LAST) begin
                  state   <= WAIT_LOCK;
                  timer   <= '0;
                  pll_rst <= 1'b0;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  timer <= '0;
               end else if (timer == WAIT_LAST) begin
                  state       <= RST_PLL;
                  timer       <= '0;
                  pll_rst     <= 1'b1;
                  timeout_err <= 1'b1;
                  timeout_cnt <= sat_inc(timeout_cnt);
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  timer <= '0;
               end else if (timer == STABLE_LAST) begin
                  state     <= RUN;
                  timer     <= '0;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state         <= RST_PLL;
                  timer         <= '0;
                  pll_rst       <= 1'b1;
                  sys_rst_n     <= 1'b0;
                  ready         <= 1'b0;
                  lock_loss_cnt <= sat_inc(lock_loss_cnt);
               end
            end
            default: state <= RST_PLL;
         endcase
         // A clear wins over any increment in the same cycle.
         if (clear_stats) begin
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
            timeout_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short intervals
// (reset pulse 4, lock timeout 32, stable window 8, 4-bit counters).
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

   logic       clk_25MHz = 1'b0;
   logic       rstn = 1'b0;
   logic       locked_async = 1'b0;
   logic       clear_stats = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       timeout_err;
   logic [3:0] lock_loss_cnt;
   logic [3:0] timeout_cnt;

   int total = 0;
   int bad = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (32),
      .LOCK_STABLE_CYCLES  (8),
      .CNT_W               (4)
   ) dut (
      .clk_25MHz     (clk_25MHz),
      .rstn          (rstn),
      .locked_async  (locked_async),
      .clear_stats   (clear_stats),
      .pll_rst       (pll_rst),
      .sys_rst_n     (sys_rst_n),
      .ready         (ready),
      .timeout_err   (timeout_err),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   task automatic tick();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Holds rstn low across one edge (edge 0), checks reset values, then releases.
   task automatic reset_pulse(input string tag);
      rstn = 1'b0;
      locked_async = 1'b0;
      tick();
      chk({tag, "_pll_rst"}, int'(pll_rst), 1);
      chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
      chk({tag, "_ready"}, int'(ready), 0);
      chk({tag, "_timeout_err"}, int'(timeout_err), 0);
      chk({tag, "_lock_loss_cnt"}, int'(lock_loss_cnt), 0);
      chk({tag, "_timeout_cnt"}, int'(timeout_cnt), 0);
      rstn = 1'b1;
   endtask

   // Lock rises at edge 10, locked_s at 12, STABLE at 13, RUN at 20.
   task automatic bringup_check(input int n, input string tag);
      for (int e = 1; e <= n; e++) begin
         tick();
         if (e == 10) locked_async = 1'b1;
         chk($sformatf("%s_pll_rst e=%0d", tag, e), int'(pll_rst), int'(e < 4));
         chk($sformatf("%s_sys_rst_n e=%0d", tag, e), int'(sys_rst_n), int'(e >= 20));
         chk($sformatf("%s_ready e=%0d", tag, e), int'(ready), int'(e >= 20));
      end
   endtask

   task automatic wait_ready(input int limit, input string tag);
      int k = 0;
      while (!ready && k < limit) begin
         tick();
         k++;
      end
      chk({tag, "_wait_ready"}, int'(ready), 1);
   endtask

   // One-cycle lock drop while in RUN; the loss registers on the third edge.
   task automatic lose_run(input logic with_clear, input int exp_cnt, input string tag);
      locked_async = 1'b0;
      tick();
      locked_async = 1'b1;
      tick();
      clear_stats = with_clear;
      tick();
      clear_stats = 1'b0;
      chk({tag, "_ready"}, int'(ready), 0);
      chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
      chk({tag, "_lock_loss_cnt"}, int'(lock_loss_cnt), exp_cnt);
   endtask

   initial begin
      repeat (3) tick();

      // Clean bring-up
      reset_pulse("rst0");
      bringup_check(25, "clean");

      // Unstable lock, then loss in RUN, then re-lock
      reset_pulse("rst1");
      for (int e = 1; e <= 60; e++) begin
         tick();
         if (e == 10 || e == 16 || e == 41) locked_async = 1'b1;
         if (e == 15 || e == 40) locked_async = 1'b0;
         chk($sformatf("unst_sys_rst_n e=%0d", e), int'(sys_rst_n),
             int'((e >= 26 && e < 43) || e >= 55));
         chk($sformatf("unst_ready e=%0d", e), int'(ready),
             int'((e >= 26 && e < 43) || e >= 55));
         chk($sformatf("unst_pll_rst e=%0d", e), int'(pll_rst),
             int'(e < 4 || (e >= 43 && e < 47)));
         chk($sformatf("unst_lock_loss_cnt e=%0d", e), int'(lock_loss_cnt), int'(e >= 43));
      end

      // Lock timeout retry: 36-cycle period, 4-cycle pulses
      reset_pulse("rst2");
      for (int e = 1; e <= 110; e++) begin
         tick();
         chk($sformatf("tmo_pll_rst e=%0d", e), int'(pll_rst), int'((e % 36) < 4));
         chk($sformatf("tmo_cnt e=%0d", e), int'(timeout_cnt), e / 36);
         chk($sformatf("tmo_err e=%0d", e), int'(timeout_err), int'(e >= 36));
         chk($sformatf("tmo_sys_rst_n e=%0d", e), int'(sys_rst_n), 0);
      end

      // Saturation of lock_loss_cnt, then clear colliding with a loss
      locked_async = 1'b1;
      wait_ready(60, "sat_start");
      for (int i = 1; i <= 17; i++) begin
         lose_run(1'b0, (i > 15) ? 15 : i, $sformatf("sat_loss%0d", i));
         wait_ready(40, $sformatf("sat_relock%0d", i));
      end
      chk("sat_timeout_cnt_before_clear", int'(timeout_cnt), 3);
      lose_run(1'b1, 0, "clear_at_sat");
      chk("clear_timeout_cnt", int'(timeout_cnt), 0);
      chk("clear_timeout_err", int'(timeout_err), 0);
      wait_ready(40, "clear_relock1");
      lose_run(1'b1, 0, "clear_from_zero");
      wait_ready(40, "clear_relock2");
      lose_run(1'b0, 1, "after_clear");
      wait_ready(40, "after_clear_relock");

      // Reset during RUN, then during STABLE
      reset_pulse("rst_in_run");
      bringup_check(15, "pre_stable");
      reset_pulse("rst_in_stable");
      bringup_check(25, "post_stable_rst");
      reset_pulse("rst_in_run2");
      bringup_check(25, "post_run_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
